fft_frame_sequencer: RTL

- Sequences the 16-point CORDIC FFT core (main_cordic_fft).
- Accepts a serial stream of complex 16-bit samples and assembles a 16-sample frame, then presents it to the core's parallel inputs.
- Waits the core's fixed latency, captures the 256-bit xout/yout buses, and streams the 16 bins out serially.
- Sits between the sample source and the FFT core. It is the core's only driver.

---
 rtl/fft_seq_pkg.sv | 17 +
 rtl/fft_seq_frame_buf.sv | 42 ++++
 rtl/fft_frame_sequencer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/fft_seq_pkg.sv
// rtl/fft_seq_pkg.sv - shared constants, state encoding and bit-reverse helper for the FFT frame sequencer
package fft_seq_pkg;

  localparam int N = 16;
  localparam int W = 16;

  localparam logic [1:0] ST_FILL  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  // Reverses the four bits of a bin number (0->0, 1->8, 2->4, ...).
  function automatic logic [3:0] bitrev4(input logic [3:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

endpackage

// File: rtl/fft_seq_frame_buf.sv
// rtl/fft_seq_frame_buf.sv - 16-entry write-indexed complex frame register file with parallel read-out
import fft_seq_pkg::*;

module fft_seq_frame_buf (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [3:0]       wr_idx,
  input  logic [W-1:0]     wr_x,
  input  logic [W-1:0]     wr_y,
  output logic [N*W-1:0]   rd_x,
  output logic [N*W-1:0]   rd_y
);

  logic [N*W-1:0] buf_x_q, buf_x_d;
  logic [N*W-1:0] buf_y_q, buf_y_d;

  // Write the incoming sample into slot wr_idx; slot k occupies bits [16k+15:16k].
  always_comb begin
    buf_x_d = buf_x_q;
    buf_y_d = buf_y_q;
    if (wr_en) begin
      buf_x_d[{wr_idx, 4'h0} +: W] = wr_x;
      buf_y_d[{wr_idx, 4'h0} +: W] = wr_y;
    end
  end

  // Frame storage; cleared on reset so an aborted frame leaves nothing behind.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      buf_x_q <= '0;
      buf_y_q <= '0;
    end else begin
      buf_x_q <= buf_x_d;
      buf_y_q <= buf_y_d;
    end
  end

  assign rd_x = buf_x_q;
  assign rd_y = buf_y_q;

endmodule

// File: rtl/fft_frame_sequencer.sv
// rtl/fft_frame_sequencer.sv - FILL/LOAD/WAIT/DRAIN sequencer around the 16-point CORDIC FFT core; FFT_BITREV_EN selects bit-reversed drain order
import fft_seq_pkg::*;

module fft_frame_sequencer #(
  parameter int CORE_LATENCY = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [W-1:0]     s_x,
  input  logic [W-1:0]     s_y,
  output logic [N*W-1:0]   core_xin,
  output logic [N*W-1:0]   core_yin,
  input  logic [N*W-1:0]   core_xout,
  input  logic [N*W-1:0]   core_yout,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [W-1:0]     m_x,
  output logic [W-1:0]     m_y,
  output logic [3:0]       m_index,
  output logic             m_last,
  output logic             busy,
  output logic [15:0]      frame_count
);

  localparam logic [7:0] LAT = 8'(CORE_LATENCY);

  logic [1:0]     state_q, state_d;
  logic [3:0]     fill_cnt_q, fill_cnt_d;
  logic [3:0]     drain_cnt_q, drain_cnt_d;
  logic [7:0]     wait_cnt_q, wait_cnt_d;
  logic [N*W-1:0] xin_q, xin_d;
  logic [N*W-1:0] yin_q, yin_d;
  logic [N*W-1:0] res_x_q, res_x_d;
  logic [N*W-1:0] res_y_q, res_y_d;
  logic [15:0]    frame_count_q, frame_count_d;

  logic           buf_wr;
  logic [N*W-1:0] buf_x;
  logic [N*W-1:0] buf_y;
  logic [3:0]     out_idx;

  fft_seq_frame_buf u_frame_buf (
    .clock   (clock),
    .reset_n (reset_n),
    .wr_en   (buf_wr),
    .wr_idx  (fill_cnt_q),
    .wr_x    (s_x),
    .wr_y    (s_y),
    .rd_x    (buf_x),
    .rd_y    (buf_y)
  );

  // Next-state logic: fill the frame, hand it to the core, wait its latency, then stream the bins.
  always_comb begin
    state_d       = state_q;
    fill_cnt_d    = fill_cnt_q;
    drain_cnt_d   = drain_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    xin_d         = xin_q;
    yin_d         = yin_q;
    res_x_d       = res_x_q;
    res_y_d       = res_y_q;
    frame_count_d = frame_count_q;
    buf_wr        = 1'b0;
    case (state_q)
      ST_FILL: begin
        if (s_valid) begin
          buf_wr     = 1'b1;
          fill_cnt_d = fill_cnt_q + 4'd1;
          if (fill_cnt_q == 4'd15) begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        xin_d      = buf_x;
        yin_d      = buf_y;
        wait_cnt_d = LAT;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        // Capture happens on the cycle the counter is already at zero, which
        // gives the core one full cycle of margin beyond its stated latency.
        if (wait_cnt_q == 8'd0) begin
          res_x_d = core_xout;
          res_y_d = core_yout;
          state_d = ST_DRAIN;
        end else begin
          wait_cnt_d = wait_cnt_q - 8'd1;
        end
      end
      ST_DRAIN: begin
        if (m_ready) begin
          drain_cnt_d = drain_cnt_q + 4'd1;
          if (drain_cnt_q == 4'd15) begin
            drain_cnt_d   = 4'd0;
            frame_count_d = frame_count_q + 16'd1;
            state_d       = ST_FILL;
          end
        end
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  // State, counters, core input hold registers and captured results.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_FILL;
      fill_cnt_q    <= 4'd0;
      drain_cnt_q   <= 4'd0;
      wait_cnt_q    <= 8'd0;
      xin_q         <= '0;
      yin_q         <= '0;
      res_x_q       <= '0;
      res_y_q       <= '0;
      frame_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      fill_cnt_q    <= fill_cnt_d;
      drain_cnt_q   <= drain_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      xin_q         <= xin_d;
      yin_q         <= yin_d;
      res_x_q       <= res_x_d;
      res_y_q       <= res_y_d;
      frame_count_q <= frame_count_d;
    end
  end

`ifdef FFT_BITREV_EN
  assign out_idx = bitrev4(drain_cnt_q);
`else
  assign out_idx = drain_cnt_q;
`endif

  assign s_ready     = (state_q == ST_FILL);
  assign m_valid     = (state_q == ST_DRAIN);
  assign m_x         = res_x_q[{out_idx, 4'h0} +: W];
  assign m_y         = res_y_q[{out_idx, 4'h0} +: W];
  assign m_index     = out_idx;
  assign m_last      = (state_q == ST_DRAIN) && (drain_cnt_q == 4'd15);
  assign busy        = (state_q != ST_FILL) || (fill_cnt_q != 4'd0);
  assign frame_count = frame_count_q;
  assign core_xin    = xin_q;
  assign core_yin    = yin_q;

endmodule
